// File: rtl/bp_fe_queue_ckpt_fifo_if.sv
// rtl/bp_fe_queue_ckpt_fifo_if.sv - FE/BE handshake bundle for the checkpointing FE queue
interface bp_fe_queue_ckpt_fifo_if #(
    parameter int width_p = 128
);
    logic [width_p-1:0] fe_queue_i;
    logic               fe_queue_v_i;
    logic               fe_queue_ready_o;
    logic [width_p-1:0] fe_queue_o;
    logic               fe_queue_v_o;
    logic               fe_queue_yumi_i;
    logic               fe_queue_deq_i;
    logic               fe_queue_roll_i;
    logic               fe_queue_clr_i;

    modport master (
        output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
               fe_queue_roll_i, fe_queue_clr_i,
        input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o
    );

    modport slave (
        input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
               fe_queue_roll_i, fe_queue_clr_i,
        output fe_queue_ready_o, fe_queue_o, fe_queue_v_o
    );
endinterface

// File: rtl/bp_fe_queue_ckpt_fifo.sv
// rtl/bp_fe_queue_ckpt_fifo.sv - checkpointing FE->BE FIFO with speculative read, retire, replay and flush (optional same-cycle bypass: BP_FE_QUEUE_BYPASS_EN)
module bp_fe_queue_ckpt_fifo #(
    parameter int els_p   = 8,
    parameter int width_p = 128
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_fe_queue_ckpt_fifo_if.slave   fe_queue_if
);
    localparam int ptr_w = $clog2(els_p) + 1;
    localparam logic [ptr_w-1:0] ptr_one  = ptr_w'(1);
    localparam logic [ptr_w-1:0] ptr_full = ptr_w'(els_p);

    // wptr: next free slot; rptr: next entry to present; cptr: oldest unretired entry.
    logic [ptr_w-1:0]   wptr, rptr, cptr;
    logic [ptr_w-1:0]   cptr_next;
    logic [width_p-1:0] mem [els_p];

    logic full, unread_empty, ready, enq, yumi_ok, deq_ok, bypass;

    // Occupancy and handshake qualification; only clr reaches ready combinationally.
    always_comb begin
        full         = (wptr - cptr) == ptr_full;
        unread_empty = (wptr == rptr);
        ready        = !full && !fe_queue_if.fe_queue_clr_i;
        enq          = fe_queue_if.fe_queue_v_i && ready;
`ifdef BP_FE_QUEUE_BYPASS_EN
        bypass       = unread_empty && enq;
`else
        bypass       = 1'b0;
`endif
        yumi_ok      = fe_queue_if.fe_queue_yumi_i && (!unread_empty || bypass);
        deq_ok       = fe_queue_if.fe_queue_deq_i && (cptr != rptr);
        cptr_next    = deq_ok ? (cptr + ptr_one) : cptr;
    end

    // Output presentation: stored entry at rptr, or the incoming packet when bypassing.
    always_comb begin
        fe_queue_if.fe_queue_ready_o = ready;
        fe_queue_if.fe_queue_v_o     = !unread_empty || bypass;
        fe_queue_if.fe_queue_o       = bypass ? fe_queue_if.fe_queue_i
                                              : mem[rptr[ptr_w-2:0]];
    end

    // Pointer update: clr wins over roll, roll wins over yumi; deq and enqueue are independent.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else if (fe_queue_if.fe_queue_clr_i) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + ptr_one;
            end
            cptr <= cptr_next;
            if (fe_queue_if.fe_queue_roll_i) begin
                rptr <= cptr_next;
            end else if (yumi_ok) begin
                rptr <= rptr + ptr_one;
            end
        end
    end

    // Packet storage; kept even when bypassed so a later roll can replay it.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr[ptr_w-2:0]] <= fe_queue_if.fe_queue_i;
        end
    end
endmodule

// File: tb/tb_bp_fe_queue_ckpt_fifo.sv
// tb/tb_bp_fe_queue_ckpt_fifo.sv - self-checking bench for bp_fe_queue_ckpt_fifo
module tb_bp_fe_queue_ckpt_fifo;
    localparam int ELS = 8;
    localparam int W   = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_fe_queue_ckpt_fifo_if #(.width_p(W)) bus ();

    bp_fe_queue_ckpt_fifo #(.els_p(ELS), .width_p(W)) dut (
        .clk_i      (clk),
        .reset_n_i  (rst_n),
        .fe_queue_if(bus.slave)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: stored entries oldest-first, plus how many of them the BE has consumed.
    logic [W-1:0] mq[$];
    int           mcons;

    task automatic model_out(output logic ev, output logic er, output logic [W-1:0] ed);
        er = (mq.size() < ELS) && !bus.fe_queue_clr_i;
        ev = mcons < mq.size();
        ed = ev ? mq[mcons] : '0;
`ifdef BP_FE_QUEUE_BYPASS_EN
        if (!ev && bus.fe_queue_v_i && er) begin
            ev = 1'b1;
            ed = bus.fe_queue_i;
        end
`endif
    endtask

    task automatic model_step();
        logic ev, er;
        logic [W-1:0] ed;
        model_out(ev, er, ed);
        if (bus.fe_queue_clr_i) begin
            mq.delete();
            mcons = 0;
        end else begin
            if (bus.fe_queue_deq_i && mcons > 0) begin
                void'(mq.pop_front());
                mcons--;
            end
            if (bus.fe_queue_roll_i) mcons = 0;
            else if (bus.fe_queue_yumi_i && ev) mcons++;
            if (bus.fe_queue_v_i && er) mq.push_back(bus.fe_queue_i);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic y,
                         input logic dq, input logic r, input logic c);
        bus.fe_queue_v_i    = v;
        bus.fe_queue_i      = d;
        bus.fe_queue_yumi_i = y;
        bus.fe_queue_deq_i  = dq;
        bus.fe_queue_roll_i = r;
        bus.fe_queue_clr_i  = c;
    endtask

    // Clock the currently driven inputs in and leave time just after the edge.
    task automatic edge_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic y,
                       input logic dq, input logic r, input logic c);
        drive(v, d, y, dq, r, c);
        #3;
        edge_step();
    endtask

    task automatic do_reset();
        drive(0, '0, 0, 0, 0, 0);
        rst_n = 1'b0;
        mq.delete();
        mcons = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         y, dq, r, c;
        logic         ev, er;
        logic [W-1:0] ed;
        logic         chk;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(logic v, logic [W-1:0] d, logic y, logic dq, logic r, logic c,
                                logic ev, logic er, logic [W-1:0] ed, logic chk);
        vec_t t;
        t.v = v; t.d = d; t.y = y; t.dq = dq; t.r = r; t.c = c;
        t.ev = ev; t.er = er; t.ed = ed; t.chk = chk;
        return t;
    endfunction

    initial begin
        logic ev, er;
        logic [W-1:0] ed;

        // Expected outputs are those seen before the row's edge.
        tbl[0]  = mk(1, 32'h1, 0, 0, 0, 0,  0, 1, 32'h0, 0);
        tbl[1]  = mk(1, 32'h2, 0, 0, 0, 0,  1, 1, 32'h1, 1);
        tbl[2]  = mk(1, 32'h3, 0, 0, 0, 0,  1, 1, 32'h1, 1);
        tbl[3]  = mk(1, 32'h4, 0, 0, 0, 0,  1, 1, 32'h1, 1);
        tbl[4]  = mk(0, 32'h0, 1, 0, 0, 0,  1, 1, 32'h1, 1);
        tbl[5]  = mk(0, 32'h0, 1, 0, 0, 0,  1, 1, 32'h2, 1);
        tbl[6]  = mk(0, 32'h0, 1, 0, 0, 0,  1, 1, 32'h3, 1);
        tbl[7]  = mk(0, 32'h0, 0, 1, 0, 0,  1, 1, 32'h4, 1);
        tbl[8]  = mk(0, 32'h0, 0, 0, 1, 0,  1, 1, 32'h4, 1);
        tbl[9]  = mk(0, 32'h0, 1, 0, 0, 0,  1, 1, 32'h2, 1);
        tbl[10] = mk(0, 32'h0, 1, 0, 0, 0,  1, 1, 32'h3, 1);
        tbl[11] = mk(0, 32'h0, 1, 0, 0, 0,  1, 1, 32'h4, 1);
        tbl[12] = mk(0, 32'h0, 0, 0, 0, 0,  0, 1, 32'h0, 1);
        tbl[13] = mk(0, 32'h0, 0, 0, 0, 1,  0, 0, 32'h0, 1);
        tbl[14] = mk(1, 32'h1, 0, 0, 0, 0,  0, 1, 32'h0, 0);
        tbl[15] = mk(1, 32'h2, 0, 0, 0, 0,  1, 1, 32'h1, 1);
        tbl[16] = mk(1, 32'h3, 0, 0, 0, 0,  1, 1, 32'h1, 1);
        tbl[17] = mk(0, 32'h0, 1, 0, 0, 0,  1, 1, 32'h1, 1);
        tbl[18] = mk(0, 32'h0, 1, 0, 0, 0,  1, 1, 32'h2, 1);
        tbl[19] = mk(0, 32'h0, 0, 1, 1, 0,  1, 1, 32'h3, 1);
        tbl[20] = mk(0, 32'h0, 0, 0, 0, 0,  1, 1, 32'h2, 1);
        tbl[21] = mk(1, 32'h55, 1, 1, 0, 1, 1, 0, 32'h2, 1);
        tbl[22] = mk(0, 32'h0, 0, 0, 0, 0,  0, 1, 32'h0, 1);
        tbl[23] = mk(1, 32'hA, 0, 0, 0, 0,  0, 1, 32'h0, 0);
        tbl[24] = mk(0, 32'h0, 0, 0, 0, 0,  1, 1, 32'hA, 1);

        do_reset();
        #3;
        check("reset_ready", {31'b0, bus.fe_queue_ready_o}, 1);
        check("reset_v", {31'b0, bus.fe_queue_v_o}, 0);

        // Directed table: replay after roll, deq+roll, clr with concurrent traffic.
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].dq, tbl[i].r, tbl[i].c);
            #3;
            check($sformatf("tbl%0d_ready", i), {31'b0, bus.fe_queue_ready_o}, {31'b0, tbl[i].er});
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d_v", i), {31'b0, bus.fe_queue_v_o}, {31'b0, tbl[i].ev});
                if (tbl[i].ev) check($sformatf("tbl%0d_data", i), bus.fe_queue_o, tbl[i].ed);
            end
            edge_step();
        end

        // Async reset while holding three entries.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, W'(32'h10 + i), 0, 0, 0, 0);
        drive(0, '0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        mq.delete();
        mcons = 0;
        #1;
        check("async_rst_v", {31'b0, bus.fe_queue_v_o}, 0);
        check("async_rst_ready", {31'b0, bus.fe_queue_ready_o}, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 32'hA, 0, 0, 0, 0);
        drive(0, '0, 0, 0, 0, 0);
        #3;
        check("post_rst_v", {31'b0, bus.fe_queue_v_o}, 1);
        check("post_rst_data", bus.fe_queue_o, 32'hA);
        edge_step();

        // Fill to capacity, consume all, then enqueue+deq while full.
        do_reset();
        for (int i = 0; i < ELS; i++) begin
            drive(1, W'(32'h100 + i), 0, 0, 0, 0);
            #3;
            check($sformatf("fill%0d_ready", i), {31'b0, bus.fe_queue_ready_o}, 1);
            edge_step();
        end
        drive(0, '0, 0, 0, 0, 0);
        #3;
        check("full_ready", {31'b0, bus.fe_queue_ready_o}, 0);
        check("full_v", {31'b0, bus.fe_queue_v_o}, 1);
        for (int i = 0; i < ELS; i++) begin
            drive(0, '0, 1, 0, 0, 0);
            #3;
            check($sformatf("drain%0d_data", i), bus.fe_queue_o, W'(32'h100 + i));
            edge_step();
        end
        drive(0, '0, 0, 0, 0, 0);
        #3;
        check("consumed_v", {31'b0, bus.fe_queue_v_o}, 0);
        check("consumed_ready", {31'b0, bus.fe_queue_ready_o}, 0);
        cyc(1, 32'h99, 0, 1, 0, 0);
        #3;
        check("deq_full_ready", {31'b0, bus.fe_queue_ready_o}, 1);
        check("deq_full_v", {31'b0, bus.fe_queue_v_o}, 0);
        edge_step();

`ifdef BP_FE_QUEUE_BYPASS_EN
        do_reset();
        drive(1, 32'h77, 1, 0, 0, 0);
        #3;
        check("bypass_v", {31'b0, bus.fe_queue_v_o}, 1);
        check("bypass_data", bus.fe_queue_o, 32'h77);
        edge_step();
        drive(0, '0, 0, 0, 0, 0);
        #3;
        check("bypass_after_v", {31'b0, bus.fe_queue_v_o}, 0);
        edge_step();
        cyc(0, '0, 0, 0, 1, 0);
        #3;
        check("bypass_roll_v", {31'b0, bus.fe_queue_v_o}, 1);
        check("bypass_roll_data", bus.fe_queue_o, 32'h77);
        edge_step();
`endif

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 5,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 59) == 0);
            #3;
            model_out(ev, er, ed);
            check("rnd_ready", {31'b0, bus.fe_queue_ready_o}, {31'b0, er});
            check("rnd_v", {31'b0, bus.fe_queue_v_o}, {31'b0, ev});
            if (ev) check("rnd_data", bus.fe_queue_o, ed);
            edge_step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
